// File: rtl/sync_register_pipe_if.sv
// Control/handshake bundle for sync_register_pipe: input word, output word,
// flush and occupancy. The pipeline connects through the slave modport.
interface sync_register_pipe_if #(
  parameter int NUM_W = 4,
  parameter int BIT_W = 3
);
  logic             flush_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic             raddr_rst_i;
  logic [NUM_W-1:0] ctrl_regnum_sel_i;
  logic [BIT_W-1:0] ctrl_regbit_sel_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic             rdata_rst_o;
  logic [NUM_W-1:0] rdata_regnum_o;
  logic [BIT_W-1:0] rdata_regbit_o;
  logic [2:0]       occ_o;

  modport slave (
    input  flush_i, in_valid_i, raddr_rst_i, ctrl_regnum_sel_i, ctrl_regbit_sel_i, out_ready_i,
    output in_ready_o, out_valid_o, rdata_rst_o, rdata_regnum_o, rdata_regbit_o, occ_o
  );

  modport master (
    output flush_i, in_valid_i, raddr_rst_i, ctrl_regnum_sel_i, ctrl_regbit_sel_i, out_ready_i,
    input  in_ready_o, out_valid_o, rdata_rst_o, rdata_regnum_o, rdata_regbit_o, occ_o
  );
endinterface

// File: rtl/sync_register_pipe.sv
// Elastic STAGES-deep alignment pipe for input-buffer read-select controls.
// Macro SYNC_REG_BIT_ALIGN_EN routes the register-bit select through the stages too.
module sync_register_pipe #(
  parameter int NUM_W  = 4,
  parameter int BIT_W  = 3,
  parameter int STAGES = 2
) (
  input  logic                 SYS_CLK,
  input  logic                 SYS_RST,
  sync_register_pipe_if.slave  bus
);

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("sync_register_pipe: STAGES must be in 1..4");
  end
  if (NUM_W < 1 || BIT_W < 1) begin : g_bad_width
    $error("sync_register_pipe: NUM_W and BIT_W must be at least 1");
  end

  localparam logic [4:0] STG5 = 5'(STAGES);
  localparam logic [2:0] STG3 = 3'(STAGES);

  // Handshake: a word moves across a boundary on a rising edge where both valid
  // and ready are high; valid never depends on ready, and a stalled stage holds.
  logic [STAGES:0]   rdy;
  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] rst_q, rst_d;
  logic [NUM_W-1:0]  num_q [STAGES];
  logic [NUM_W-1:0]  num_d [STAGES];
`ifdef SYNC_REG_BIT_ALIGN_EN
  logic [BIT_W-1:0]  bit_q [STAGES];
  logic [BIT_W-1:0]  bit_d [STAGES];
`endif
  logic [2:0]        occ_q, occ_d;
  logic [4:0]        occ_raw;
  logic              in_fire, out_fire;

  always_comb begin
    rdy = '0;
    rdy[STAGES] = bus.out_ready_i;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = !v_q[k] | rdy[k+1];
    end
  end

  // Bubbles advance the valid bit only; data registers load real words alone.
  always_comb begin
    v_d   = v_q;
    rst_d = rst_q;
    num_d = num_q;
`ifdef SYNC_REG_BIT_ALIGN_EN
    bit_d = bit_q;
`endif
    if (bus.flush_i) begin
      v_d = '0;
    end else begin
      if (rdy[0]) begin
        v_d[0] = bus.in_valid_i;
        if (bus.in_valid_i) begin
          rst_d[0] = bus.raddr_rst_i;
          num_d[0] = bus.ctrl_regnum_sel_i;
`ifdef SYNC_REG_BIT_ALIGN_EN
          bit_d[0] = bus.ctrl_regbit_sel_i;
`endif
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (rdy[k]) begin
          v_d[k] = v_q[k-1];
          if (v_q[k-1]) begin
            rst_d[k] = rst_q[k-1];
            num_d[k] = num_q[k-1];
`ifdef SYNC_REG_BIT_ALIGN_EN
            bit_d[k] = bit_q[k-1];
`endif
          end
        end
      end
    end
  end

  always_comb begin
    in_fire  = bus.in_valid_i & bus.in_ready_o;
    out_fire = v_q[STAGES-1] & bus.out_ready_i;
    occ_raw  = {2'b00, occ_q} + {4'b0000, in_fire} - {4'b0000, out_fire};
    if (bus.flush_i) begin
      occ_d = '0;
    end else if (occ_raw > STG5) begin
      occ_d = occ_raw[4] ? 3'd0 : STG3;
    end else begin
      occ_d = occ_raw[2:0];
    end
  end

  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      v_q   <= '0;
      rst_q <= '0;
      occ_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        num_q[k] <= '0;
`ifdef SYNC_REG_BIT_ALIGN_EN
        bit_q[k] <= '0;
`endif
      end
    end else begin
      v_q   <= v_d;
      rst_q <= rst_d;
      occ_q <= occ_d;
      for (int k = 0; k < STAGES; k++) begin
        num_q[k] <= num_d[k];
`ifdef SYNC_REG_BIT_ALIGN_EN
        bit_q[k] <= bit_d[k];
`endif
      end
    end
  end

  // Occupancy tracks the valid bits exactly, so saturation should never engage.
  occ_in_range_a: assert property (@(posedge SYS_CLK) disable iff (SYS_RST)
    bus.flush_i || (occ_raw <= STG5));

  assign bus.in_ready_o     = rdy[0] & !bus.flush_i;
  assign bus.out_valid_o    = v_q[STAGES-1];
  assign bus.rdata_rst_o    = rst_q[STAGES-1];
  assign bus.rdata_regnum_o = num_q[STAGES-1];
  assign bus.occ_o          = occ_q;
`ifdef SYNC_REG_BIT_ALIGN_EN
  assign bus.rdata_regbit_o = bit_q[STAGES-1];
`else
  assign bus.rdata_regbit_o = bus.ctrl_regbit_sel_i;
`endif

endmodule
